// File: rtl/movx_bus_ctrl_if.sv
// Bus bundle between the core sequencer / pads and the MOVX bus sequencer.
// The master side drives requests and pad inputs; the slave side is the sequencer.
interface movx_bus_ctrl_if;
    logic       start;
    logic       is_write;
    logic       use_dptr;
    logic [7:0] dptr_h;
    logic [7:0] dptr_l;
    logic [7:0] ri_addr;
    logic [7:0] p2_sfr;
    logic [7:0] wr_data;
    logic [7:0] p0_in;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] p0_out;
    logic       p0_oe;
    logic [7:0] p2_out;

    modport master (
        output start, is_write, use_dptr, dptr_h, dptr_l, ri_addr, p2_sfr, wr_data, p0_in,
        input  busy, done, rd_data, ale, rd_n, wr_n, p0_out, p0_oe, p2_out
    );

    modport slave (
        input  start, is_write, use_dptr, dptr_h, dptr_l, ri_addr, p2_sfr, wr_data, p0_in,
        output busy, done, rd_data, ale, rd_n, wr_n, p0_out, p0_oe, p2_out
    );
endinterface

// File: rtl/movx_bus_ctrl.sv
// MOVX external data memory bus sequencer: one multiplexed 8051-style cycle
// (address under ALE, RD_n/WR_n strobe, data hold) per accepted start.
module movx_bus_ctrl #(
    parameter int ADDR_CYCLES   = 2,
    parameter int STROBE_CYCLES = 3
) (
    input logic            clock,
    input logic            reset,
    movx_bus_ctrl_if.slave bus
);

    localparam int MAX_CYC = (ADDR_CYCLES > STROBE_CYCLES) ? ADDR_CYCLES : STROBE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] ADDR_LOAD   = CW'(ADDR_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_HOLD} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [15:0]   addr_q;
    logic [7:0]    wr_data_q;
    logic          is_write_q;
    logic [7:0]    rd_data_q;

    logic          ale_q, rd_n_q, wr_n_q, p0_oe_q, done_q;
    logic [7:0]    p0_out_q;
    logic          ale_d, rd_n_d, wr_n_d, p0_oe_d, done_d;
    logic [7:0]    p0_out_d;

    logic [15:0]   addr_sel, addr_n;
    logic          cnt_zero;

    assign addr_sel = bus.use_dptr ? {bus.dptr_h, bus.dptr_l} : {bus.p2_sfr, bus.ri_addr};
    // Address as it will be after this edge, so ADDR pads are correct on the capture edge.
    assign addr_n   = (state == S_IDLE) ? addr_sel : addr_q;
    assign cnt_zero = (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (bus.start) next_state = S_ADDR;
            S_ADDR:   if (cnt_zero)  next_state = S_STROBE;
            S_STROBE: if (cnt_zero)  next_state = S_HOLD;
            S_HOLD:                  next_state = S_IDLE;
            default:                 next_state = S_IDLE;
        endcase
    end

    // Pad outputs are computed for the state being entered and registered,
    // keeping start off any combinational path to the pads.
    always_comb begin
        ale_d    = 1'b0;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        p0_oe_d  = 1'b0;
        p0_out_d = 8'hFF;
        done_d   = (state == S_HOLD);
        case (next_state)
            S_ADDR: begin
                ale_d    = 1'b1;
                p0_oe_d  = 1'b1;
                p0_out_d = addr_n[7:0];
            end
            S_STROBE: begin
                if (is_write_q) begin
                    wr_n_d   = 1'b0;
                    p0_oe_d  = 1'b1;
                    p0_out_d = wr_data_q;
                end else begin
                    rd_n_d   = 1'b0;
                end
            end
            S_HOLD: begin
                if (is_write_q) begin
                    p0_oe_d  = 1'b1;
                    p0_out_d = wr_data_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ale_q    <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            p0_oe_q  <= 1'b0;
            p0_out_q <= 8'hFF;
            done_q   <= 1'b0;
        end else begin
            ale_q    <= ale_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            p0_oe_q  <= p0_oe_d;
            p0_out_q <= p0_out_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            is_write_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    addr_q     <= addr_sel;
                    wr_data_q  <= bus.wr_data;
                    is_write_q <= bus.is_write;
                    cnt        <= ADDR_LOAD;
                end
                S_ADDR:   cnt <= cnt_zero ? STROBE_LOAD : cnt - 1'b1;
                S_STROBE: begin
                    if (!cnt_zero)        cnt       <= cnt - 1'b1;
                    else if (!is_write_q) rd_data_q <= bus.p0_in;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_q;
    assign bus.rd_data = rd_data_q;
    assign bus.ale     = ale_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.p0_out  = p0_out_q;
    assign bus.p0_oe   = p0_oe_q;
    assign bus.p2_out  = (state == S_IDLE) ? bus.p2_sfr : addr_q[15:8];

endmodule

// File: tb/tb_movx_bus_ctrl.sv
// Bench for movx_bus_ctrl: default timing and ADDR/STROBE=1 instances driven in
// parallel, checked cycle by cycle against a phase-arithmetic reference model.
module tb_movx_bus_ctrl;

    localparam int A0 = 2, S0 = 3;
    localparam int A1 = 1, S1 = 1;

    typedef struct packed {
        logic       busy, done, ale, rd_n, wr_n, oe;
        logic [7:0] p0, p2, rd;
    } outs_t;

    typedef struct {
        bit         wr, ud;
        logic [7:0] dh, dl, ri, p2, wd, p0;
        logic [15:0] exp_addr;
        logic [7:0] exp_rd;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, is_write = 1'b0, use_dptr = 1'b0;
    logic [7:0] dptr_h = '0, dptr_l = '0, ri_addr = '0, p2_sfr = 8'h5A, wr_data = '0, p0_in = '0;

    int n_pass = 0, n_total = 0;
    logic [7:0] rd_m0 = '0, rd_m1 = '0;

    always #5 clock = ~clock;

    movx_bus_ctrl_if bus0 ();
    movx_bus_ctrl_if bus1 ();

    assign bus0.start = start;    assign bus1.start = start;
    assign bus0.is_write = is_write; assign bus1.is_write = is_write;
    assign bus0.use_dptr = use_dptr; assign bus1.use_dptr = use_dptr;
    assign bus0.dptr_h = dptr_h;  assign bus1.dptr_h = dptr_h;
    assign bus0.dptr_l = dptr_l;  assign bus1.dptr_l = dptr_l;
    assign bus0.ri_addr = ri_addr; assign bus1.ri_addr = ri_addr;
    assign bus0.p2_sfr = p2_sfr;  assign bus1.p2_sfr = p2_sfr;
    assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
    assign bus0.p0_in = p0_in;    assign bus1.p0_in = p0_in;

    movx_bus_ctrl #(.ADDR_CYCLES(A0), .STROBE_CYCLES(S0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
    movx_bus_ctrl #(.ADDR_CYCLES(A1), .STROBE_CYCLES(S1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

    outs_t act0, act1;
    assign act0 = {bus0.busy, bus0.done, bus0.ale, bus0.rd_n, bus0.wr_n, bus0.p0_oe, bus0.p0_out, bus0.p2_out, bus0.rd_data};
    assign act1 = {bus1.busy, bus1.done, bus1.ale, bus1.rd_n, bus1.wr_n, bus1.p0_oe, bus1.p0_out, bus1.p2_out, bus1.rd_data};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected outputs in cycle i after the capture edge, from phase lengths alone.
    function automatic outs_t model(input int a, input int s, input int i, input bit wr,
                                    input logic [15:0] addr, input logic [7:0] wd,
                                    input logic [7:0] p2_now, input logic [7:0] rd);
        outs_t e;
        e = '{busy: 1'b1, done: 1'b0, ale: 1'b0, rd_n: 1'b1, wr_n: 1'b1, oe: 1'b0,
              p0: 8'hFF, p2: addr[15:8], rd: rd};
        if (i < a) begin
            e.ale = 1'b1; e.oe = 1'b1; e.p0 = addr[7:0];
        end else if (i < a + s) begin
            e.rd_n = wr; e.wr_n = !wr; e.oe = wr; e.p0 = wr ? wd : 8'hFF;
        end else if (i == a + s) begin
            e.oe = wr; e.p0 = wr ? wd : 8'hFF;
        end else begin
            e.busy = 1'b0; e.done = (i == a + s + 1); e.p2 = p2_now;
        end
        return e;
    endfunction

    // P0 is don't-care while the bus is turned around for a read.
    function automatic logic [31:0] masked(input outs_t x, input outs_t e);
        if (e.busy && !e.oe) x.p0 = 8'h00;
        return 32'(x);
    endfunction

    function automatic outs_t idle_exp(input logic [7:0] rd);
        return '{busy: 1'b0, done: 1'b0, ale: 1'b0, rd_n: 1'b1, wr_n: 1'b1, oe: 1'b0,
                 p0: 8'hFF, p2: p2_sfr, rd: rd};
    endfunction

    task automatic scramble(input bit fixed_p0, input logic [7:0] p0v);
        is_write = 1'($urandom);
        use_dptr = 1'($urandom);
        dptr_h   = 8'($urandom);
        dptr_l   = 8'($urandom);
        ri_addr  = 8'($urandom);
        p2_sfr   = 8'($urandom);
        wr_data  = 8'($urandom);
        p0_in    = fixed_p0 ? p0v : 8'($urandom);
    endtask

    // Called at a negedge with both instances idle; returns at dut0's done-cycle negedge.
    task automatic run_txn(input string name, input bit wr, input bit ud,
                           input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] ri,
                           input logic [7:0] p2, input logic [7:0] wd, input logic [15:0] exp_addr,
                           input bit fixed_p0, input logic [7:0] p0v);
        logic [7:0] hist [0:15];
        logic [7:0] rd0, rd1;
        outs_t e0, e1;
        is_write = wr; use_dptr = ud; dptr_h = dh; dptr_l = dl;
        ri_addr = ri; p2_sfr = p2; wr_data = wd;
        p0_in = fixed_p0 ? p0v : 8'($urandom);
        start = 1'b1;
        for (int i = 0; i <= A0 + S0 + 1; i++) begin
            @(negedge clock);
            rd0 = (!wr && i >= A0 + S0) ? hist[A0 + S0 - 1] : rd_m0;
            rd1 = (!wr && i >= A1 + S1) ? hist[A1 + S1 - 1] : rd_m1;
            e0 = model(A0, S0, i, wr, exp_addr, wd, p2_sfr, rd0);
            e1 = model(A1, S1, i, wr, exp_addr, wd, p2_sfr, rd1);
            check($sformatf("%s dut0 c%0d", name, i), masked(act0, e0), masked(e0, e0));
            check($sformatf("%s dut1 c%0d", name, i), masked(act1, e1), masked(e1, e1));
            start = 1'b0;
            scramble(fixed_p0, p0v);
            hist[i] = p0_in;
        end
        if (!wr) begin
            rd_m0 = hist[A0 + S0 - 1];
            rd_m1 = hist[A1 + S1 - 1];
        end
    endtask

    initial begin
        vec_t vecs [4];
        int d0, d1;
        logic [7:0] t_dh, t_dl, t_ri, t_p2, t_wd;
        bit t_wr, t_ud;

        vecs[0] = '{wr: 1'b0, ud: 1'b1, dh: 8'h12, dl: 8'h34, ri: 8'h00, p2: 8'h5A, wd: 8'h00, p0: 8'hA5, exp_addr: 16'h1234, exp_rd: 8'hA5};
        vecs[1] = '{wr: 1'b1, ud: 1'b0, dh: 8'h77, dl: 8'h66, ri: 8'h80, p2: 8'h01, wd: 8'h3C, p0: 8'h00, exp_addr: 16'h0180, exp_rd: 8'hA5};
        vecs[2] = '{wr: 1'b0, ud: 1'b0, dh: 8'h99, dl: 8'h88, ri: 8'hFE, p2: 8'hC3, wd: 8'h11, p0: 8'h5A, exp_addr: 16'hC3FE, exp_rd: 8'h5A};
        vecs[3] = '{wr: 1'b1, ud: 1'b1, dh: 8'hFF, dl: 8'hFF, ri: 8'h42, p2: 8'h24, wd: 8'h00, p0: 8'hFF, exp_addr: 16'hFFFF, exp_rd: 8'h5A};

        // Reset state with no start.
        @(negedge clock);
        check("reset dut0", 32'(act0), 32'(idle_exp(8'h00)));
        check("reset dut1", 32'(act1), 32'(idle_exp(8'h00)));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post-reset dut0", 32'(act0), 32'(idle_exp(8'h00)));
        check("post-reset dut1", 32'(act1), 32'(idle_exp(8'h00)));

        // Directed vectors; consecutive calls also exercise back-to-back acceptance.
        foreach (vecs[k]) begin
            run_txn($sformatf("vec%0d", k), vecs[k].wr, vecs[k].ud, vecs[k].dh, vecs[k].dl,
                    vecs[k].ri, vecs[k].p2, vecs[k].wd, vecs[k].exp_addr, 1'b1, vecs[k].p0);
            check($sformatf("vec%0d rd_data", k), 32'(bus0.rd_data), 32'(vecs[k].exp_rd));
        end

        // Randomized accesses against the model.
        for (int r = 0; r < 30; r++) begin
            t_wr = 1'($urandom); t_ud = 1'($urandom);
            t_dh = 8'($urandom); t_dl = 8'($urandom); t_ri = 8'($urandom);
            t_p2 = 8'($urandom); t_wd = 8'($urandom);
            run_txn($sformatf("rnd%0d", r), t_wr, t_ud, t_dh, t_dl, t_ri, t_p2, t_wd,
                    t_ud ? {t_dh, t_dl} : {t_p2, t_ri}, 1'b0, 8'h00);
        end
        @(negedge clock);

        // Start held high: one access per (A+S+2) clocks, ale right after done.
        is_write = 1'b1; use_dptr = 1'b1; dptr_h = 8'h20; dptr_l = 8'h40; wr_data = 8'h99;
        start = 1'b1;
        d0 = 0; d1 = 0;
        for (int i = 0; i <= 23; i++) begin
            @(negedge clock);
            d0 += int'(bus0.done);
            d1 += int'(bus1.done);
            if (i == 6) check("b2b done0 at +6", 32'(bus0.done), 32'd1);
            if (i == 7) check("b2b ale0 after done", 32'({bus0.ale, bus0.busy}), 32'b11);
            if (i == 20) start = 1'b0;
        end
        check("b2b done count dut0", 32'(d0), 32'd3);
        check("b2b done count dut1", 32'(d1), 32'd6);

        // Start pulses while busy are dropped.
        start = 1'b1;
        d0 = 0; d1 = 0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clock);
            d0 += int'(bus0.done);
            d1 += int'(bus1.done);
            start = (i == 1 || i == 2);
        end
        check("ignore done count dut0", 32'(d0), 32'd1);
        check("ignore done count dut1", 32'(d1), 32'd1);

        // Asynchronous reset on dut0's second strobe clock.
        is_write = 1'b0; use_dptr = 1'b1; dptr_h = 8'hAB; dptr_l = 8'hCD; p0_in = 8'h77;
        start = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clock);
            start = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        check("async reset dut0", 32'(act0), 32'(idle_exp(8'h00)));
        check("async reset dut1", 32'(act1), 32'(idle_exp(8'h00)));
        rd_m0 = 8'h00; rd_m1 = 8'h00;
        @(negedge clock);
        check("held reset dut0", 32'(act0), 32'(idle_exp(8'h00)));
        reset = 1'b0;
        @(negedge clock);
        run_txn("after-reset", 1'b0, 1'b1, 8'h12, 8'h34, 8'h00, 8'h5A, 8'h00, 16'h1234, 1'b1, 8'hA5);
        check("after-reset rd_data", 32'(bus0.rd_data), 32'h0000_00A5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
